alu_sequencer: RTL and testbench

Multi-cycle issue/sequencing front end for the KGP-miniRISC ALU. It accepts operation requests over a valid/ready handshake and maps each one to one or two ALU passes. It drives the ALU's `input1`/`input2`/`control` from registers and captures `out`/`flags` at the end of each pass. It returns result and flags over a second valid/ready handshake. It sits between the decode/register-read stage and the ALU instance.

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_op_decode.sv | 33 +++
 rtl/alu_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and ALU control encodings for the ALU issue/sequencing front end.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    COMP = 4'd2,
    AND  = 4'd3,
    XOR  = 4'd4,
    SLL  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    TEST = 4'd8
  } op_e;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_COMP = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_XOR  = 5'b00011;
  localparam logic [4:0] ALU_SLL  = 5'b01100;
  localparam logic [4:0] ALU_SRL  = 5'b01101;
  localparam logic [4:0] ALU_SRA  = 5'b01110;
  localparam logic [4:0] ALU_NOP  = 5'b00111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op decode: first-pass ALU control, pass count, legality and
// whether the ALU carry is meaningful for this op.
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  output logic [4:0] ctl,
  output logic       two_pass,
  output logic       legal,
  output logic       carry_valid
);

  always_comb begin
    ctl         = ALU_NOP;
    two_pass    = 1'b0;
    legal       = 1'b1;
    carry_valid = 1'b0;
    case (op_e'(op))
      ADD:  begin ctl = ALU_ADD;  carry_valid = 1'b1; end
      // SUB negates B first, then adds it to A on a second pass.
      SUB:  begin ctl = ALU_COMP; carry_valid = 1'b1; two_pass = 1'b1; end
      COMP: ctl = ALU_COMP;
      AND:  ctl = ALU_AND;
      XOR:  ctl = ALU_XOR;
      SLL:  ctl = ALU_SLL;
      SRL:  ctl = ALU_SRL;
      SRA:  ctl = ALU_SRA;
      TEST: ctl = ALU_AND;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences each request into one or two registered ALU passes and returns
// result/flags over a valid/ready response held stable until accepted.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [4:0]       req_shamt,
  input  logic             req_shamt_sel,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [4:0]       alu_control,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [2:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_flags,
  output logic             rsp_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d, tmp_q, tmp_d;
  logic [4:0]       ctl_q, ctl_d;
  logic             two_pass_q, two_pass_d, carry_q, carry_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       flags_q, flags_d;
  logic             err_q, err_d;

  logic [4:0] dec_ctl;
  logic       dec_two_pass, dec_legal, dec_carry;
  logic [4:0] amt;

  alu_op_decode u_dec (
    .op          (req_op),
    .ctl         (dec_ctl),
    .two_pass    (dec_two_pass),
    .legal       (dec_legal),
    .carry_valid (dec_carry)
  );

  assign amt = req_shamt_sel ? req_b[4:0] : req_shamt;

  always_comb begin
    state_d    = state_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    ctl_d      = ctl_q;
    tmp_d      = tmp_q;
    two_pass_d = two_pass_q;
    carry_d    = carry_q;
    data_d     = data_q;
    flags_d    = flags_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (dec_legal) begin
            state_d    = PASS1;
            in1_d      = req_a;
            ctl_d      = dec_ctl;
            two_pass_d = dec_two_pass;
            carry_d    = dec_carry;
            err_d      = 1'b0;
            if (dec_ctl[3])
              in2_d = {{(WIDTH-5){1'b0}}, amt};
            else if (req_op == TEST)
              in2_d = '1;
            else
              in2_d = req_b;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            data_d  = '0;
            flags_d = '0;
          end
        end
      end
      PASS1: begin
        tmp_d  = alu_out;
        data_d = alu_out;
        if (two_pass_q) begin
          state_d = PASS2;
          ctl_d   = ALU_ADD;
        end else begin
          state_d = RESP;
          flags_d = {carry_q & alu_flags[2], alu_flags[1:0]};
        end
      end
      PASS2: begin
        data_d  = alu_out;
        flags_d = {carry_q & alu_flags[2], alu_flags[1:0]};
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          in1_d   = '0;
          in2_d   = '0;
          ctl_d   = ALU_NOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in1_q      <= '0;
      in2_q      <= '0;
      ctl_q      <= ALU_NOP;
      tmp_q      <= '0;
      two_pass_q <= 1'b0;
      carry_q    <= 1'b0;
      data_q     <= '0;
      flags_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      ctl_q      <= ctl_d;
      tmp_q      <= tmp_d;
      two_pass_q <= two_pass_d;
      carry_q    <= carry_d;
      data_q     <= data_d;
      flags_q    <= flags_d;
      err_q      <= err_d;
    end
  end

  // The SUB add pass takes its second operand straight from the tmp register.
  assign alu_in1     = in1_q;
  assign alu_in2     = (state_q == PASS2) ? tmp_q : in2_q;
  assign alu_control = ctl_q;
  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_data    = data_q;
  assign rsp_flags   = flags_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU model on the drive port.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_shamt_sel;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_shamt;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [4:0]  alu_control;
  logic [2:0]  alu_flags;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_flags;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  flags;
    logic        err;
    int          lat;
    int          n;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt), .req_shamt_sel(req_shamt_sel),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  // Behavioural KGP-miniRISC ALU.
  logic [32:0] sum;
  always_comb begin
    sum     = '0;
    alu_out = '0;
    case (alu_control)
      5'b00000: begin sum = {1'b0, alu_in1} + {1'b0, alu_in2}; alu_out = sum[31:0]; end
      5'b00001: alu_out = ~alu_in2 + 32'd1;
      5'b00010: alu_out = alu_in1 & alu_in2;
      5'b00011: alu_out = alu_in1 ^ alu_in2;
      5'b01100: alu_out = alu_in1 << alu_in2[4:0];
      5'b01101: alu_out = alu_in1 >> alu_in2[4:0];
      5'b01110: alu_out = 32'($signed(alu_in1) >>> alu_in2[4:0]);
      default:  alu_out = '0;
    endcase
    alu_flags = {sum[32], alu_in1[31], (alu_in1 == 32'd0)};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] amt, output exp_t e);
    logic [32:0] s;
    logic [31:0] nb;
    logic        c;
    c = 1'b0; e.err = 1'b0; e.lat = 2; e.data = '0; e.n = 0;
    nb = ~b + 32'd1;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; e.data = s[31:0]; c = s[32]; end
      4'd1: begin s = {1'b0, a} + {1'b0, nb}; e.data = a - b; c = s[32]; e.lat = 3; end
      4'd2: e.data = nb;
      4'd3: e.data = a & b;
      4'd4: e.data = a ^ b;
      4'd5: e.data = a << amt;
      4'd6: e.data = a >> amt;
      4'd7: e.data = 32'($signed(a) >>> amt);
      4'd8: e.data = a;
      default: begin e.err = 1'b1; e.lat = 1; end
    endcase
    e.flags = e.err ? 3'b000 : {c, a[31], (a == 32'd0)};
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic sel, output int n);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_shamt = sh; req_shamt_sel = sel;
    req_valid = 1'b1;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = cyc;
    ref_calc(op, a, b, sel ? b[4:0] : sh, e);
    e.n = n;
    sb.push_back(e);
  endtask

  task automatic recv(input int hold);
    exp_t e;
    int   w;
    w = 0;
    rsp_ready = 1'b0;
    @(negedge clk);
    while (!rsp_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", sb.size(), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("latency", cyc - e.n + 1, e.lat);
    chk("rsp_data", rsp_data, e.data);
    chk("rsp_flags", {29'd0, rsp_flags}, {29'd0, e.flags});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_data", rsp_data, e.data);
      chk("hold_flags", {29'd0, rsp_flags}, {29'd0, e.flags});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("req_ready_after", {31'd0, req_ready}, 32'd1);
    chk("rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
    req_op = 4'd0; req_a = 32'd1; req_b = 32'd1; req_shamt = '0; req_shamt_sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_flags", {29'd0, rsp_flags}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_in1", alu_in1, 32'd0);
    chk("rst_in2", alu_in2, 32'd0);
    chk("rst_ctl", {27'd0, alu_control}, 32'd7);
    req_valid = 1'b0;
    rst_n = 1'b1;

    send(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, n); recv(0);

    send(4'd1, 32'd5, 32'd7, 5'd0, 1'b0, n);
    @(negedge clk);
    chk("sub_ctl_p1", {27'd0, alu_control}, 32'b00001);
    chk("sub_in2_p1", alu_in2, 32'd7);
    @(negedge clk);
    chk("sub_ctl_p2", {27'd0, alu_control}, 32'b00000);
    chk("sub_in1_p2", alu_in1, 32'd5);
    chk("sub_in2_p2", alu_in2, 32'hFFFF_FFF9);
    recv(0);

    send(4'd7, 32'h8000_0000, 32'd0, 5'd4, 1'b0, n); recv(0);

    send(4'd5, 32'd1, 32'h23, 5'd17, 1'b1, n);
    @(negedge clk);
    chk("sll_in2", alu_in2, 32'd3);
    chk("sll_ctl", {27'd0, alu_control}, 32'b01100);
    recv(0);

    send(4'd8, 32'd0, 32'h1234, 5'd0, 1'b0, n); recv(0);
    send(4'hF, 32'h55, 32'h66, 5'd0, 1'b0, n); recv(0);
    send(4'd4, 32'hA5A5_0F0F, 32'h0FF0_1234, 5'd0, 1'b0, n); recv(5);

    for (int k = 0; k < 10; k++) begin
      send(4'(k), 32'h8765_4321 + 32'(k), 32'h0000_1005, 5'(k + 3), 1'(k % 2), n);
      recv(k % 3);
    end
    for (int k = 0; k < 12; k++) begin
      send(4'($urandom_range(0, 10)), $urandom, $urandom, 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), n);
      recv($urandom_range(0, 2));
    end

    // Abort a SUB during its add pass.
    send(4'd1, 32'd9, 32'd4, 5'd0, 1'b0, n);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 1'b1; req_op = 4'd0;
    #1;
    chk("abort_ctl", {27'd0, alu_control}, 32'd7);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    chk("abort_ignore_req", {27'd0, alu_control}, 32'd7);
    req_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("post_abort_ctl", {27'd0, alu_control}, 32'd7);
    end
    send(4'd0, 32'd2, 32'd3, 5'd0, 1'b0, n); recv(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
